// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM operand info in, stall/flush controls out.
interface hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int CW = 16
);
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_branch;
    logic          br_taken;
    logic          ex_regwrite;
    logic          ex_memread;
    logic [AW-1:0] ex_rd;
    logic          mem_memread;
    logic [AW-1:0] mem_rd;
    logic          cnt_clr;
    logic          stall;
    logic          flush_idex;
    logic          flush_ifid;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, br_taken,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd, cnt_clr,
        input  stall, flush_idex, flush_ifid, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, br_taken,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd, cnt_clr,
        output stall, flush_idex, flush_ifid, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard detector with multi-cycle load wait FSM and
// a saturating stalled-cycle counter.
module hazard_ctrl #(
    parameter int AW      = 5,
    parameter int MEM_LAT = 1,
    parameter int CW      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] LAT_FULL = 3'(MEM_LAT);
    localparam logic [2:0] LAT_LESS = 3'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q;
    logic          ex_match, mem_match;
    logic          lu, ba, ble, blm, hazard;
    logic          stall;

    // Register 0 is hardwired, so it can never carry a real dependency.
    function automatic logic src_match(input logic use_s, input logic [AW-1:0] s,
                                       input logic [AW-1:0] d);
        return use_s && (s != '0) && (s == d);
    endfunction

    assign ex_match  = src_match(hz.id_use_rs, hz.id_rs, hz.ex_rd) ||
                       src_match(hz.id_use_rt, hz.id_rt, hz.ex_rd);
    assign mem_match = src_match(hz.id_use_rs, hz.id_rs, hz.mem_rd) ||
                       src_match(hz.id_use_rt, hz.id_rt, hz.mem_rd);

    assign lu     = hz.ex_memread && ex_match;
    assign ba     = hz.id_branch && hz.ex_regwrite && !hz.ex_memread && ex_match;
    assign ble    = hz.id_branch && lu;
    assign blm    = hz.id_branch && hz.mem_memread && mem_match;
    assign hazard = lu || ba || ble || blm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // The current IDLE cycle already stalls once, so WAIT covers only the rest.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (ble) begin
                    state_d = WAIT;
                    rem_d   = LAT_FULL;
                end else if ((lu || blm) && (MEM_LAT > 1)) begin
                    state_d = WAIT;
                    rem_d   = LAT_LESS;
                end
            end
            WAIT: begin
                if (rem_q <= 3'd1) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Outputs are gated by rst_n so they read 0 for the whole reset pulse.
    always_comb begin
        stall         = 1'b0;
        hz.flush_ifid = 1'b0;
        if (rst_n) begin
            stall         = (state_q == WAIT) || hazard;
            hz.flush_ifid = hz.br_taken && !stall;
        end
    end

    assign hz.stall      = stall;
    assign hz.flush_idex = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (hz.cnt_clr)
            cnt_q <= '0;
        else if (stall && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign hz.stall_cnt = cnt_q;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 5, register-address width.
REQ-002 The block SHALL have parameter MEM_LAT, default 1, legal 1..4, data-memory load latency in cycles.
REQ-003 The block SHALL have parameter CW, default 16, stall-counter width.
REQ-004 clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 id_rs, id_rt  input  AW each  source registers of the instruction in ID.
REQ-007 id_use_rs, id_use_rt  input  1 each  source actually read by the ID instruction.
REQ-008 id_branch  input  1  ID instruction is a branch resolved in ID.
REQ-009 br_taken  input  1  branch resolved taken in ID this cycle.
REQ-010 ex_regwrite, ex_memread  input  1 each  EX-stage instruction writes a register / is a load.
REQ-011 ex_rd  input  AW  EX-stage destination register.
REQ-012 mem_memread  input  1  MEM-stage instruction is a load.
REQ-013 mem_rd  input  AW  MEM-stage destination register.
REQ-014 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-015 stall  output  1  freeze PC and IF/ID.
REQ-016 flush_idex  output  1  insert bubble into ID/EX.
REQ-017 flush_ifid  output  1  squash IF/ID (taken branch).
REQ-018 stall_cnt  output  CW  saturating count of stalled cycles.

Function
REQ-019 A match on source S (rs or rt) SHALL require id_use_S=1, equal addresses and address nonzero; register 0 never causes a hazard.
REQ-020 Load-use hazard (LU): ex_memread=1 and ex_rd matches a used source, any instruction type.
REQ-021 Branch-ALU hazard (BA): id_branch=1, ex_regwrite=1, ex_memread=0, ex_rd matches.
REQ-022 Branch-load-EX hazard (BLE): id_branch=1 and LU condition true.
REQ-023 Branch-load-MEM hazard (BLM): id_branch=1, mem_memread=1, mem_rd matches.
REQ-024 FSM states SHALL be IDLE and WAIT, with a down-counter rem of width 3.
REQ-025 In IDLE, stall SHALL be the combinational OR of LU, BA, BLE, BLM.
REQ-026 In IDLE on a detected hazard, next state and rem SHALL be: BLE -> WAIT, rem=MEM_LAT; LU (non-branch) -> WAIT if MEM_LAT>1, rem=MEM_LAT-1; BLM -> WAIT if MEM_LAT>1, rem=MEM_LAT-1; BA -> stay IDLE.
REQ-027 Total stall cycles SHALL therefore be: LU = MEM_LAT, BA = 1, BLE = MEM_LAT+1, BLM = MEM_LAT.
REQ-028 In WAIT, stall SHALL be 1 regardless of comparator inputs, rem SHALL decrement each cycle, and the FSM SHALL return to IDLE on the edge where rem transitions 1 -> 0.
REQ-029 On the first IDLE cycle after WAIT, hazard detection SHALL be re-evaluated normally (back-to-back hazards allowed).
REQ-030 flush_idex SHALL equal stall in every cycle.
REQ-031 flush_ifid SHALL be br_taken AND NOT stall; stall has priority over a taken branch in the same cycle.
REQ-032 stall_cnt SHALL increment by 1 each cycle stall=1, saturate at all-ones, and clear when cnt_clr=1; cnt_clr wins over increment in the same cycle.

Reset
REQ-033 While rst_n=0: state IDLE, rem=0, stall_cnt=0, and stall, flush_idex, flush_ifid SHALL all be forced 0 regardless of inputs.
REQ-034 Reset asserted during WAIT SHALL abort the wait immediately; the first cycle after release SHALL behave as IDLE.

Verification
REQ-035 MEM_LAT=1: ex_memread=1, ex_rd=8, id_rs=8, id_use_rs=1 -> stall=flush_idex=1 for exactly 1 cycle, stall_cnt=1.
REQ-036 MEM_LAT=3: branch with id_rt=9, ex_memread=1, ex_rd=9 -> stall for exactly 4 cycles, then IDLE; with id_rt=0 and ex_rd=0 -> no stall.
REQ-037 MEM_LAT=1: branch with id_rs=4, ex_regwrite=1, ex_memread=0, ex_rd=4, br_taken=1 -> cycle 1 stall=1, flush_ifid=0; next cycle (no hazard) flush_ifid=1, stall=0.
REQ-038 MEM_LAT=4: LU hazard, rst_n pulsed low on 2nd stall cycle -> all outputs 0 during reset, stall_cnt=0, no stall after release.
REQ-039 CW=4: 20 consecutive LU stalls with cnt_clr=0 -> stall_cnt holds 15; cnt_clr=1 together with stall=1 -> stall_cnt=0.
